// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buffer
// Purpose  : Two-entry registered elastic buffer between the instruction fetch
//            and decode stages, using a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_skid;
  logic [1:0]       w_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Occupancy-driven next state; flush overrides any handshake in the same cycle.
  always_comb begin
    w_head  = r_head;
    w_skid  = r_skid;
    w_count = r_count;
    if (flush) begin
      w_count = c_empty;
    end else begin
      case (r_count)
        c_empty: begin
          if (w_push) begin
            w_head  = in_data;
            w_count = c_one;
          end
        end
        c_one: begin
          if (w_push && w_pop) begin
            w_head = in_data;
          end else if (w_push) begin
            w_skid  = in_data;
            w_count = c_full;
          end else if (w_pop) begin
            w_count = c_empty;
          end
        end
        c_full: begin
          if (w_pop) begin
            w_head  = r_skid;
            w_count = c_one;
          end
        end
        default: begin
          w_count = c_empty;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next occupancy so they always agree with count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_skid      <= '0;
      r_count     <= c_empty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_head      <= w_head;
      r_skid      <= w_skid;
      r_count     <= w_count;
      r_in_ready  <= (w_count != c_full);
      r_out_valid <= (w_count != c_empty);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_skid_buffer
// Purpose  : Directed self-checking bench for fetch_skid_buffer (32-bit unit
//            plus a 2-bit instance feeding an enabled downstream register).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_skid_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;

  logic        d_in_valid;
  logic [1:0]  d_in_data;
  logic        d_in_ready;
  logic        d_out_valid;
  logic [1:0]  d_out_data;
  logic        d_out_ready;
  logic [1:0]  d_count;
  logic        d_en;
  logic [1:0]  r_q;

  int n_tests;
  int n_fail;

  fetch_skid_buffer #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  fetch_skid_buffer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
    .count(d_count)
  );

  // Downstream decode register (flipflopEN #(2) behaviour).
  assign d_en = d_out_valid & d_out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= 2'd0;
    else if (d_en) r_q <= d_out_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_q [3];
    int         k;
    int         p;
    logic       en_now;
    logic       acc;
    logic [1:0] q_prev;

    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
    tick();
    tick();
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check("rst_iready", {31'd0, in_ready}, 32'd1);
    check("rst_odata", out_data, 32'd0);
    reset = 1'b1;

    // 1: load two words then reset asynchronously mid-cycle
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    check("t1_full", {30'd0, count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t1_async_count", {30'd0, count}, 32'd0);
    check("t1_async_ovalid", {31'd0, out_valid}, 32'd0);
    check("t1_async_iready", {31'd0, in_ready}, 32'd1);
    check("t1_async_odata", out_data, 32'd0);
    reset = 1'b1;
    tick();
    check("t1_after_count", {30'd0, count}, 32'd0);
    check("t1_after_ovalid", {31'd0, out_valid}, 32'd0);

    // 2: pass-through with out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    check("t2_a", out_data, 32'hA);
    check("t2_a_count", {30'd0, count}, 32'd1);
    in_data = 32'hB;
    tick();
    check("t2_b", out_data, 32'hB);
    check("t2_b_iready", {31'd0, in_ready}, 32'd1);
    in_data = 32'hC;
    tick();
    check("t2_c", out_data, 32'hC);
    check("t2_c_count", {30'd0, count}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("t2_drain_count", {30'd0, count}, 32'd0);
    check("t2_drain_ovalid", {31'd0, out_valid}, 32'd0);
    check("t2_drain_hold", out_data, 32'hC);

    // 3: backpressure, third word must wait
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    check("t3_count2", {30'd0, count}, 32'd2);
    check("t3_iready0", {31'd0, in_ready}, 32'd0);
    in_data = 32'h33;
    tick();
    check("t3_blocked", {30'd0, count}, 32'd2);
    check("t3_head11", out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    check("t3_seq22", out_data, 32'h22);
    check("t3_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t3_seq33", out_data, 32'h33);
    check("t3_seq33_count", {30'd0, count}, 32'd1);
    tick();
    check("t3_empty", {30'd0, count}, 32'd0);

    // 4: simultaneous push and pop at count 1
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5;
    tick();
    check("t4_head5", out_data, 32'h5);
    in_data = 32'h6; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_data6", out_data, 32'h6);
    check("t4_count1", {30'd0, count}, 32'd1);
    tick();
    check("t4_empty", {30'd0, count}, 32'd0);

    // 5: flush while full with a pending push
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h88;
    tick();
    in_data = 32'h99;
    tick();
    check("t5_full", {30'd0, count}, 32'd2);
    in_data = 32'h77; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_count", {30'd0, count}, 32'd0);
    check("t5_ovalid", {31'd0, out_valid}, 32'd0);
    check("t5_iready", {31'd0, in_ready}, 32'd1);
    check("t5_hold", out_data, 32'h88);
    tick();
    check("t5_no77", out_data, 32'h88);
    check("t5_still_empty", {30'd0, count}, 32'd0);

    // 6: WIDTH=2 instance into enabled downstream register, random out_ready
    exp_q[0] = 2'd2; exp_q[1] = 2'd1; exp_q[2] = 2'd3;
    k = 0;
    p = 0;
    for (int cyc = 0; cyc < 300 && k < 3; cyc++) begin
      d_out_ready = 1'($urandom_range(0, 1));
      d_in_valid  = (p < 3);
      d_in_data   = (p < 3) ? exp_q[p] : 2'd0;
      #1;
      acc    = d_in_valid & d_in_ready;
      en_now = d_en;
      q_prev = r_q;
      tick();
      if (en_now) begin
        check($sformatf("t6_q%0d", k), {30'd0, r_q}, {30'd0, exp_q[k]});
        k++;
      end else begin
        check("t6_q_hold", {30'd0, r_q}, {30'd0, q_prev});
      end
      if (acc) p++;
    end
    d_in_valid = 1'b0;
    d_out_ready = 1'b0;
    check("t6_all_consumed", k, 32'd3);
    check("t6_empty", {30'd0, d_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
